decode_dispatch_queue: RTL and testbench
========================================

Name: decode_dispatch_queue

Overview:
- Consumer end of the decode mux output stream: captures each registered decoded instruction (enable + format/opcode/ID/operand fields) into an in-order FIFO.
- Steers the head entry to the functional unit selected by its funcUnitType code, using a per-unit valid/ready handshake.
- The decode mux has no backpressure input, so this block raises an early stall to the fetch/decode front end and flags any instruction it is forced to drop.

Parameters:
addressWidth, 64, instruction address width
instructionCounterWidth, 64, major ID width
instMinIdWidth, 7, minor ID width
opcodeSize, 12, decoded opcode width
PidSize, 20, process ID width
TidSize, 16, thread ID width
regAccessPatternSize, 2, per-operand read/write flag width
funcUnitCodeSize, 3, unit code width; unit port count = 2**funcUnitCodeSize
formatWidth, 25, one-hot instruction format width
bodyWidth, 84, operand body width (4 regs + 64b imm)
queueDepth, 4, FIFO entries; power of two, >=2

Ports:
clock_i  in  1  clock; all state updates on rising edge
reset_i  in  1  synchronous reset, active-low
flush_i  in  1  discard all queued entries (pipeline flush)
enable_i  in  1  decode mux output valid
instFormat_i  in  formatWidth  one-hot format
opcode_i  in  opcodeSize  decoded opcode
address_i  in  addressWidth  instruction address
funcUnitType_i  in  funcUnitCodeSize  destination unit code
majID_i  in  instructionCounterWidth  major ID
minID_i  in  instMinIdWidth  minor ID
is64Bit_i  in  1  64-bit mode
pid_i / tid_i  in  PidSize / TidSize  process / thread ID
op1rw_i..op4rw_i  in  regAccessPatternSize each  operand access flags
op1IsReg_i..op4IsReg_i  in  1 each  operand-is-register flags
body_i  in  bodyWidth  operands
stall_o  out  1  front end must stop issuing into decode
unitValid_o  out  2**funcUnitCodeSize  one-hot; bit k = head targets unit k
unitReady_i  in  2**funcUnitCodeSize  unit k can accept this cycle
instFormat_o..body_o  out  same widths as inputs  head entry payload, shared by all unit ports
badUnit_o  out  1  one-cycle pulse: head dropped, unit code not implemented
overflow_o  out  1  sticky: an instruction arrived while full and was dropped

Behaviour:
- Reset (reset_i==0 at a rising edge):
  - read pointer, write pointer and count go to 0; stall_o=0, unitValid_o=0, badUnit_o=0, overflow_o=0.
  - The payload storage array is not reset.
- Payload outputs are driven from the head entry combinationally and forced to all-zero when the queue is empty.
- Push: enable_i=1 and (count<queueDepth, or a pop occurs in the same cycle) writes the entry at the write pointer, which then advances modulo queueDepth.
  - Latency: enable_i sampled at edge N; entry is visible at the outputs after edge N when the queue was empty.
- Pop:
  - The head's unit code k is one of the implemented units 0,1,2,3,4,6: unitValid_o[k]=1 while count>0. The entry pops at an edge where unitReady_i[k]=1; the read pointer advances.
  - Ready bits of non-targeted units are ignored.
  - Unit code 5 or 7: unitValid_o stays 0. At the next edge the entry pops unconditionally and badUnit_o pulses high for exactly one cycle.
- Dispatch is strictly in order, one entry per cycle at most.
- Count update: push-only +1, pop-only -1, push and pop together unchanged.
  - Simultaneous push and pop at count==queueDepth is legal and does not drop the entry.
- Full:
  - enable_i=1 with count==queueDepth and no pop: the entry is dropped and overflow_o sets.
  - overflow_o clears only on reset.
- stall_o = (count >= queueDepth-1). Registered from the next-state count, so the one instruction already in flight from the registered mux always fits.
- Flush:
  - flush_i=1 at an edge zeroes count and both pointers; no pop or handshake occurs.
  - An enable_i in the same cycle is discarded and does not set overflow_o.
  - stall_o, unitValid_o and badUnit_o are all 0 on the following cycle.
- Reset takes priority over flush, flush over push/pop. Reset mid-dispatch abandons the head and no handshake is recorded.
- Pointer wrap-around is natural modulo queueDepth.

Optional Feature:
DISPATCH_PERF_EN:
- Defined: adds outputs dispatchCount_o[0:31] and stallCycles_o[0:31].
  - dispatchCount_o increments on each handshaken pop; badUnit drops are not counted.
  - stallCycles_o increments on each cycle stall_o==1.
  - Both are zeroed by reset, not by flush, and wrap at 2**32.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
1. Reset low 2 cycles, then push majID=1, unit 0, with unitReady_i=8'hFF -> unitValid_o=8'b1000_0000 the cycle after push; popped next edge; queue empty, payload outputs zero.
2. Push 4 entries (units 0,1,2,4) with unitReady_i=0 -> stall_o=1 once count reaches 3. A 5th push sets overflow_o=1; majIDs 1..4 dispatch in order once ready is raised.
3. At count=4, push majID=9 while the head pops -> no overflow; majID=9 is dispatched fourth, after the other three.
4. Push an entry with unit code 5 -> unitValid_o=0; badUnit_o high for exactly one cycle; the next entry (unit 6) reaches the head and unitValid_o=8'b0000_0010.
5. Three entries queued, assert flush_i together with enable_i -> count 0, unitValid_o=0, stall_o=0, overflow_o unchanged.
6. With DISPATCH_PERF_EN, dispatch 3 entries and hold stall for 5 cycles -> dispatchCount_o=3, stallCycles_o=5; reset clears both.

Source files
------------

// File: rtl/decode_dispatch_queue.sv
// In-order dispatch FIFO behind the decode mux: buffers decoded instructions and steers the head to its
// functional unit over a per-unit valid/ready handshake. Optional counters under DISPATCH_PERF_EN.
module decode_dispatch_queue #(
    parameter int addressWidth            = 64,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int opcodeSize              = 12,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int regAccessPatternSize    = 2,
    parameter int funcUnitCodeSize        = 3,
    parameter int formatWidth             = 25,
    parameter int bodyWidth               = 84,
    parameter int queueDepth              = 4
) (
    input  logic                                  clock_i,
    input  logic                                  reset_i,
    input  logic                                  flush_i,
    input  logic                                  enable_i,
    input  logic [formatWidth-1:0]                instFormat_i,
    input  logic [opcodeSize-1:0]                 opcode_i,
    input  logic [addressWidth-1:0]               address_i,
    input  logic [funcUnitCodeSize-1:0]           funcUnitType_i,
    input  logic [instructionCounterWidth-1:0]    majID_i,
    input  logic [instMinIdWidth-1:0]             minID_i,
    input  logic                                  is64Bit_i,
    input  logic [PidSize-1:0]                    pid_i,
    input  logic [TidSize-1:0]                    tid_i,
    input  logic [regAccessPatternSize-1:0]       op1rw_i,
    input  logic [regAccessPatternSize-1:0]       op2rw_i,
    input  logic [regAccessPatternSize-1:0]       op3rw_i,
    input  logic [regAccessPatternSize-1:0]       op4rw_i,
    input  logic                                  op1IsReg_i,
    input  logic                                  op2IsReg_i,
    input  logic                                  op3IsReg_i,
    input  logic                                  op4IsReg_i,
    input  logic [bodyWidth-1:0]                  body_i,
    output logic                                  stall_o,
    output logic [0:(1<<funcUnitCodeSize)-1]      unitValid_o,
    input  logic [0:(1<<funcUnitCodeSize)-1]      unitReady_i,
    output logic [formatWidth-1:0]                instFormat_o,
    output logic [opcodeSize-1:0]                 opcode_o,
    output logic [addressWidth-1:0]               address_o,
    output logic [funcUnitCodeSize-1:0]           funcUnitType_o,
    output logic [instructionCounterWidth-1:0]    majID_o,
    output logic [instMinIdWidth-1:0]             minID_o,
    output logic                                  is64Bit_o,
    output logic [PidSize-1:0]                    pid_o,
    output logic [TidSize-1:0]                    tid_o,
    output logic [regAccessPatternSize-1:0]       op1rw_o,
    output logic [regAccessPatternSize-1:0]       op2rw_o,
    output logic [regAccessPatternSize-1:0]       op3rw_o,
    output logic [regAccessPatternSize-1:0]       op4rw_o,
    output logic                                  op1IsReg_o,
    output logic                                  op2IsReg_o,
    output logic                                  op3IsReg_o,
    output logic                                  op4IsReg_o,
    output logic [bodyWidth-1:0]                  body_o,
`ifdef DISPATCH_PERF_EN
    output logic [0:31]                           dispatchCount_o,
    output logic [0:31]                           stallCycles_o,
`endif
    output logic                                  badUnit_o,
    output logic                                  overflow_o
);

    localparam int NUM_UNITS = 1 << funcUnitCodeSize;
    localparam int PTR_W     = $clog2(queueDepth);
    localparam int CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(queueDepth);
    localparam logic [CNT_W-1:0] DEPTH_M1_C   = CNT_W'(queueDepth - 1);

    typedef struct packed {
        logic [formatWidth-1:0]             instFormat;
        logic [opcodeSize-1:0]              opcode;
        logic [addressWidth-1:0]            address;
        logic [funcUnitCodeSize-1:0]        funcUnitType;
        logic [instructionCounterWidth-1:0] majID;
        logic [instMinIdWidth-1:0]          minID;
        logic                               is64Bit;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
        logic [regAccessPatternSize-1:0]    op1rw;
        logic [regAccessPatternSize-1:0]    op2rw;
        logic [regAccessPatternSize-1:0]    op3rw;
        logic [regAccessPatternSize-1:0]    op4rw;
        logic                               op1IsReg;
        logic                               op2IsReg;
        logic                               op3IsReg;
        logic                               op4IsReg;
        logic [bodyWidth-1:0]               body;
    } entry_t;

    // Unit codes 5 and 7 have no functional unit behind them.
    function automatic logic unit_implemented(input logic [funcUnitCodeSize-1:0] code);
        return !(code == funcUnitCodeSize'(5) || code == funcUnitCodeSize'(7));
    endfunction

    entry_t                 mem_q [queueDepth];
    entry_t                 mem_d [queueDepth];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   stall_q, stall_d;
    logic                   bad_unit_q, bad_unit_d;
    logic                   overflow_q, overflow_d;
    entry_t                 in_entry, head, out_entry;
    logic                   not_empty, head_impl, head_ready, pop, push;
    logic [0:NUM_UNITS-1]   unit_valid;
`ifdef DISPATCH_PERF_EN
    logic [31:0]            dispatch_count_q, dispatch_count_d;
    logic [31:0]            stall_cycles_q, stall_cycles_d;
`endif

    always_comb begin
        in_entry = '{instFormat: instFormat_i, opcode: opcode_i, address: address_i,
                     funcUnitType: funcUnitType_i, majID: majID_i, minID: minID_i,
                     is64Bit: is64Bit_i, pid: pid_i, tid: tid_i,
                     op1rw: op1rw_i, op2rw: op2rw_i, op3rw: op3rw_i, op4rw: op4rw_i,
                     op1IsReg: op1IsReg_i, op2IsReg: op2IsReg_i,
                     op3IsReg: op3IsReg_i, op4IsReg: op4IsReg_i, body: body_i};

        not_empty  = (count_q != '0);
        head       = mem_q[rd_ptr_q];
        head_impl  = unit_implemented(head.funcUnitType);
        head_ready = unitReady_i[head.funcUnitType];

        // An unimplemented head drains unconditionally so the queue never deadlocks.
        pop  = !flush_i && not_empty && (!head_impl || head_ready);
        push = !flush_i && enable_i && ((count_q < DEPTH_C) || pop);

        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        count_d    = count_q;
        if (push && !pop) count_d = count_q + CNT_W'(1);
        if (pop && !push) count_d = count_q - CNT_W'(1);
        overflow_d = overflow_q | (!flush_i && enable_i && !push);
        bad_unit_d = pop && !head_impl;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
        // Looking at next-state count leaves room for the instruction already in the mux register.
        stall_d = (count_d >= DEPTH_M1_C);

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = in_entry;

        unit_valid = '0;
        if (not_empty && head_impl) unit_valid[head.funcUnitType] = 1'b1;
        out_entry = not_empty ? head : '0;

`ifdef DISPATCH_PERF_EN
        dispatch_count_d = dispatch_count_q + 32'(pop && head_impl);
        stall_cycles_d   = stall_cycles_q + 32'(stall_q);
`endif
    end

    always_ff @(posedge clock_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            bad_unit_q <= 1'b0;
            overflow_q <= 1'b0;
`ifdef DISPATCH_PERF_EN
            dispatch_count_q <= '0;
            stall_cycles_q   <= '0;
`endif
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            bad_unit_q <= bad_unit_d;
            overflow_q <= overflow_d;
`ifdef DISPATCH_PERF_EN
            dispatch_count_q <= dispatch_count_d;
            stall_cycles_q   <= stall_cycles_d;
`endif
        end
    end

    assign stall_o        = stall_q;
    assign badUnit_o      = bad_unit_q;
    assign overflow_o     = overflow_q;
    assign unitValid_o    = unit_valid;
    assign instFormat_o   = out_entry.instFormat;
    assign opcode_o       = out_entry.opcode;
    assign address_o      = out_entry.address;
    assign funcUnitType_o = out_entry.funcUnitType;
    assign majID_o        = out_entry.majID;
    assign minID_o        = out_entry.minID;
    assign is64Bit_o      = out_entry.is64Bit;
    assign pid_o          = out_entry.pid;
    assign tid_o          = out_entry.tid;
    assign op1rw_o        = out_entry.op1rw;
    assign op2rw_o        = out_entry.op2rw;
    assign op3rw_o        = out_entry.op3rw;
    assign op4rw_o        = out_entry.op4rw;
    assign op1IsReg_o     = out_entry.op1IsReg;
    assign op2IsReg_o     = out_entry.op2IsReg;
    assign op3IsReg_o     = out_entry.op3IsReg;
    assign op4IsReg_o     = out_entry.op4IsReg;
    assign body_o         = out_entry.body;
`ifdef DISPATCH_PERF_EN
    assign dispatchCount_o = dispatch_count_q;
    assign stallCycles_o   = stall_cycles_q;
`endif

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Bench for decode_dispatch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_decode_dispatch_queue;

    localparam int PW = 308;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b0, flush_i = 1'b0, enable_i = 1'b0;
    logic [24:0]   instFormat_i = '0;
    logic [11:0]   opcode_i = '0;
    logic [63:0]   address_i = '0;
    logic [2:0]    funcUnitType_i = '0;
    logic [63:0]   majID_i = '0;
    logic [6:0]    minID_i = '0;
    logic          is64Bit_i = 1'b0;
    logic [19:0]   pid_i = '0;
    logic [15:0]   tid_i = '0;
    logic [1:0]    op1rw_i = '0, op2rw_i = '0, op3rw_i = '0, op4rw_i = '0;
    logic          op1IsReg_i = 1'b0, op2IsReg_i = 1'b0, op3IsReg_i = 1'b0, op4IsReg_i = 1'b0;
    logic [83:0]   body_i = '0;
    logic [0:7]    unitReady_i = '0;

    logic          stall_o, badUnit_o, overflow_o;
    logic [0:7]    unitValid_o;
    logic [24:0]   instFormat_o;
    logic [11:0]   opcode_o;
    logic [63:0]   address_o;
    logic [2:0]    funcUnitType_o;
    logic [63:0]   majID_o;
    logic [6:0]    minID_o;
    logic          is64Bit_o;
    logic [19:0]   pid_o;
    logic [15:0]   tid_o;
    logic [1:0]    op1rw_o, op2rw_o, op3rw_o, op4rw_o;
    logic          op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o;
    logic [83:0]   body_o;
`ifdef DISPATCH_PERF_EN
    logic [0:31]   dispatchCount_o, stallCycles_o;
`endif

    decode_dispatch_queue dut (
        .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .enable_i(enable_i),
        .instFormat_i(instFormat_i), .opcode_i(opcode_i), .address_i(address_i),
        .funcUnitType_i(funcUnitType_i), .majID_i(majID_i), .minID_i(minID_i),
        .is64Bit_i(is64Bit_i), .pid_i(pid_i), .tid_i(tid_i),
        .op1rw_i(op1rw_i), .op2rw_i(op2rw_i), .op3rw_i(op3rw_i), .op4rw_i(op4rw_i),
        .op1IsReg_i(op1IsReg_i), .op2IsReg_i(op2IsReg_i), .op3IsReg_i(op3IsReg_i),
        .op4IsReg_i(op4IsReg_i), .body_i(body_i),
        .stall_o(stall_o), .unitValid_o(unitValid_o), .unitReady_i(unitReady_i),
        .instFormat_o(instFormat_o), .opcode_o(opcode_o), .address_o(address_o),
        .funcUnitType_o(funcUnitType_o), .majID_o(majID_o), .minID_o(minID_o),
        .is64Bit_o(is64Bit_o), .pid_o(pid_o), .tid_o(tid_o),
        .op1rw_o(op1rw_o), .op2rw_o(op2rw_o), .op3rw_o(op3rw_o), .op4rw_o(op4rw_o),
        .op1IsReg_o(op1IsReg_o), .op2IsReg_o(op2IsReg_o), .op3IsReg_o(op3IsReg_o),
        .op4IsReg_o(op4IsReg_o), .body_o(body_o),
`ifdef DISPATCH_PERF_EN
        .dispatchCount_o(dispatchCount_o), .stallCycles_o(stallCycles_o),
`endif
        .badUnit_o(badUnit_o), .overflow_o(overflow_o)
    );

    // Clock and reset
    always #5 clock_i = ~clock_i;

    // Reference model: queue of payloads and their unit codes
    logic [PW-1:0] exp_q[$];
    logic [2:0]    unit_q[$];
    logic          m_over = 1'b0, m_stall = 1'b0, m_bad = 1'b0;
    int unsigned   m_disp = 0, m_scyc = 0;
    int            errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic implemented(input logic [2:0] u);
        return (u != 3'd5) && (u != 3'd7);
    endfunction

    task automatic check_outputs();
        logic [0:7]    ev;
        logic [PW-1:0] obs;
        ev = '0;
        if (unit_q.size() > 0 && implemented(unit_q[0])) ev[unit_q[0]] = 1'b1;
        obs = {instFormat_o, opcode_o, address_o, funcUnitType_o, majID_o, minID_o, is64Bit_o,
               pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o, op4rw_o,
               op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, body_o};
        chk("unit_valid", PW'(unitValid_o), PW'(ev));
        chk("payload", obs, (exp_q.size() > 0) ? exp_q[0] : '0);
        chk("stall", PW'(stall_o), PW'(m_stall));
        chk("bad_unit", PW'(badUnit_o), PW'(m_bad));
        chk("overflow", PW'(overflow_o), PW'(m_over));
`ifdef DISPATCH_PERF_EN
        chk("dispatch_count", PW'(dispatchCount_o), PW'(m_disp));
        chk("stall_cycles", PW'(stallCycles_o), PW'(m_scyc));
`endif
    endtask

    // Driver: apply one cycle of inputs, advance the model, then check after the edge
    task automatic step(input logic rst, input logic fl, input logic en, input logic [2:0] unit,
                        input logic [63:0] maj, input logic [0:7] rdy);
        logic [PW-1:0] pl;
        logic          pop, push, impl;
        reset_i = rst; flush_i = fl; enable_i = en; funcUnitType_i = unit; majID_i = maj;
        unitReady_i = rdy;
        instFormat_i = 25'(1) << $urandom_range(0, 24);
        opcode_i = 12'($urandom); address_i = {$urandom, $urandom}; minID_i = 7'($urandom);
        is64Bit_i = 1'($urandom); pid_i = 20'($urandom); tid_i = 16'($urandom);
        {op1rw_i, op2rw_i, op3rw_i, op4rw_i} = 8'($urandom);
        {op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i} = 4'($urandom);
        body_i = {20'($urandom), $urandom, $urandom};
        pl = {instFormat_i, opcode_i, address_i, funcUnitType_i, majID_i, minID_i, is64Bit_i,
              pid_i, tid_i, op1rw_i, op2rw_i, op3rw_i, op4rw_i,
              op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i, body_i};
        if (!rst) begin
            exp_q.delete(); unit_q.delete();
            m_over = 0; m_stall = 0; m_bad = 0; m_disp = 0; m_scyc = 0;
        end else begin
            m_scyc += 32'(m_stall);
            if (fl) begin
                exp_q.delete(); unit_q.delete();
                m_stall = 0; m_bad = 0;
            end else begin
                pop = 0; impl = 0;
                if (unit_q.size() > 0) begin
                    impl = implemented(unit_q[0]);
                    pop  = !impl || rdy[unit_q[0]];
                end
                push = en && (exp_q.size() < 4 || pop);
                if (en && !push) m_over = 1;
                m_bad = pop && !impl;
                if (pop && impl) m_disp++;
                if (pop) begin void'(exp_q.pop_front()); void'(unit_q.pop_front()); end
                if (push) begin exp_q.push_back(pl); unit_q.push_back(unit); end
                m_stall = (exp_q.size() >= 3);
            end
        end
        @(posedge clock_i);
        @(negedge clock_i);
        check_outputs();
    endtask

    initial begin
        @(negedge clock_i);
        // 1: single dispatch to unit 0
        step(0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        step(1, 0, 1, 3'd0, 64'd1, 8'hFF);
        chk("t1_valid", PW'(unitValid_o), PW'(8'b1000_0000));
        chk("t1_maj", PW'(majID_o), PW'(64'd1));
        step(1, 0, 0, 0, 0, 8'hFF);
        chk("t1_empty_maj", PW'(majID_o), '0);

        // 2: fill, stall, overflow, in-order drain
        step(0, 0, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 1, (i == 4) ? 3'd4 : 3'(i - 1), 64'(i), 8'h00);
            if (i == 3) chk("t2_stall", PW'(stall_o), PW'(1'b1));
        end
        step(1, 0, 1, 3'd0, 64'd5, 8'h00);
        chk("t2_overflow", PW'(overflow_o), PW'(1'b1));
        for (int i = 1; i <= 4; i++) begin
            chk("t2_order", PW'(majID_o), PW'(64'(i)));
            step(1, 0, 0, 0, 0, 8'hFF);
        end

        // 3: push while full with a simultaneous pop
        step(0, 0, 0, 0, 0, 8'h00);
        for (int i = 5; i <= 8; i++) step(1, 0, 1, 3'(i - 5), 64'(i), 8'h00);
        step(1, 0, 1, 3'd0, 64'd9, 8'hFF);
        chk("t3_no_overflow", PW'(overflow_o), PW'(1'b0));
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 8'hFF);
        chk("t3_fourth", PW'(majID_o), PW'(64'd9));
        step(1, 0, 0, 0, 0, 8'hFF);

        // 4: unimplemented unit code drains with a one-cycle pulse
        step(0, 0, 0, 0, 0, 8'h00);
        step(1, 0, 1, 3'd5, 64'd20, 8'hFF);
        chk("t4_valid0", PW'(unitValid_o), '0);
        step(1, 0, 1, 3'd6, 64'd21, 8'h00);
        chk("t4_bad", PW'(badUnit_o), PW'(1'b1));
        chk("t4_valid6", PW'(unitValid_o), PW'(8'b0000_0010));
        step(1, 0, 0, 0, 0, 8'h00);
        chk("t4_bad_once", PW'(badUnit_o), PW'(1'b0));

        // 5: flush with a concurrent enable
        step(1, 0, 1, 3'd1, 64'd22, 8'h00);
        step(1, 0, 1, 3'd2, 64'd23, 8'h00);
        step(1, 1, 1, 3'd3, 64'd24, 8'h00);
        chk("t5_valid", PW'(unitValid_o), '0);
        chk("t5_stall", PW'(stall_o), PW'(1'b0));

`ifdef DISPATCH_PERF_EN
        // 6: perf counters
        step(0, 0, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 3; i++) step(1, 0, 1, 3'd0, 64'(i), 8'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 8'hFF);
        chk("t6_dispatch", PW'(dispatchCount_o), PW'(32'd3));
        chk("t6_stall", PW'(stallCycles_o), PW'(32'd5));
        step(0, 0, 0, 0, 0, 8'h00);
        chk("t6_rst_dispatch", PW'(dispatchCount_o), '0);
`endif

        // Random traffic
        step(0, 0, 0, 0, 0, 8'h00);
        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 149) != 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)),
                 {$urandom, $urandom}, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
